// File: rtl/dice_pkg.sv
// Shared types and constants for the dice game control path.
package dice_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROLL  = 2'd1,
        FINAL = 2'd2
    } state_e;

    localparam logic [2:0] FACE_MIN  = 3'd1;
    localparam logic [2:0] FACE_MAX  = 3'd6;
    localparam logic [7:0] LFSR_SEED = 8'h5A;
    localparam int         CLK_HZ    = 1000000;

    // Advance the face by 1..5 positions around the ring 1..6, so it always changes.
    function automatic logic [2:0] next_face(input logic [2:0] face, input logic [7:0] lfsr);
        logic [3:0] step;
        logic [3:0] sum;
        step = 4'(lfsr % 8'd5) + 4'd1;
        sum  = {1'b0, face} - {1'b0, FACE_MIN} + step;
        if (sum >= {1'b0, FACE_MAX})
            sum = sum - {1'b0, FACE_MAX};
        return 3'(sum + {1'b0, FACE_MIN});
    endfunction

endpackage

// File: rtl/dice_roll_ctrl_btn_debounce.sv
// Button conditioning: 2-flop synchroniser, stability counter, rising-edge press pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 20000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Press is registered alongside the level so it lands 2+DEBOUNCE_CYC cycles after a clean edge.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/dice_roll_ctrl.sv
// Dice control: debounced roll button, animated roll, final face hold.
// Define DICE_DECEL_EN to lengthen each successive step period (visible slow-down).
import dice_pkg::*;

module dice_roll_ctrl #(
    parameter int DEBOUNCE_CYC   = 20000,
    parameter int ROLL_STEP_CYC  = 50000,
    parameter int ROLL_STEPS     = 30,
    parameter int FINAL_HOLD_CYC = 5400000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    output logic [2:0] face,
    output logic       rolling,
    output logic       is_final,
    output logic       roll_done
);

    localparam int HW = $clog2(FINAL_HOLD_CYC + 1);

    state_e        state_q, state_d;
    logic [23:0]   timer_q, timer_d;
    logic [7:0]    steps_q, steps_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [7:0]    lfsr_q, lfsr_d;
    logic [2:0]    face_q, face_d;
    logic          rolling_q, rolling_d;
    logic          is_final_q, is_final_d;
    logic          roll_done_q, roll_done_d;
    logic          press;
    logic          step_end;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn),
        .press (press)
    );

`ifdef DICE_DECEL_EN
    logic [23:0] period;
    assign period   = 24'(ROLL_STEP_CYC) + 24'(steps_q) * 24'(ROLL_STEP_CYC >> 3);
    assign step_end = (timer_q == period - 24'd1);
`else
    assign step_end = (timer_q == 24'(ROLL_STEP_CYC - 1));
`endif

    // All-zero lock-up state can only arise from an upset; reseed.
    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        if (lfsr_q == 8'h00)
            lfsr_d = LFSR_SEED;
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        steps_d     = steps_q;
        hold_d      = hold_q;
        face_d      = face_q;
        roll_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (press) begin
                    state_d = ROLL;
                    timer_d = '0;
                    steps_d = '0;
                end
            end
            ROLL: begin
                if (step_end) begin
                    face_d  = next_face(face_q, lfsr_q);
                    steps_d = steps_q + 8'd1;
                    timer_d = '0;
                    if (steps_q == 8'(ROLL_STEPS - 1)) begin
                        state_d     = FINAL;
                        roll_done_d = 1'b1;
                        hold_d      = '0;
                    end
                end else begin
                    timer_d = timer_q + 24'd1;
                end
            end
            FINAL: begin
                hold_d = hold_q + 1'b1;
                // A re-roll press takes priority over hold expiry.
                if (press) begin
                    state_d = ROLL;
                    timer_d = '0;
                    steps_d = '0;
                end else if (hold_q == HW'(FINAL_HOLD_CYC - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        rolling_d  = (state_d == ROLL);
        is_final_d = (state_d == FINAL);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            steps_q     <= '0;
            hold_q      <= '0;
            lfsr_q      <= LFSR_SEED;
            face_q      <= FACE_MIN;
            rolling_q   <= 1'b0;
            is_final_q  <= 1'b0;
            roll_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            steps_q     <= steps_d;
            hold_q      <= hold_d;
            lfsr_q      <= lfsr_d;
            face_q      <= face_d;
            rolling_q   <= rolling_d;
            is_final_q  <= is_final_d;
            roll_done_q <= roll_done_d;
        end
    end

    assign face      = face_q;
    assign rolling   = rolling_q;
    assign is_final  = is_final_q;
    assign roll_done = roll_done_q;

endmodule

// File: tb/tb_dice_roll_ctrl.sv
// Directed bench for dice_roll_ctrl with shortened timing parameters.
`define CHK(tag, obs, exp) begin checks++; assert ((obs) === (exp)) else begin failures++; $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp); end end

module tb_dice_roll_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn = 1'b0;
    logic [2:0] face;
    logic       rolling, is_final, roll_done;

    int checks = 0;
    int failures = 0;

    dice_roll_ctrl #(
        .DEBOUNCE_CYC   (4),
        .ROLL_STEP_CYC  (10),
        .ROLL_STEPS     (3),
        .FINAL_HOLD_CYC (50)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn       (btn),
        .face      (face),
        .rolling   (rolling),
        .is_final  (is_final),
        .roll_done (roll_done)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Raise btn and count cycles until rolling rises (bounded).
    task automatic press_wait(output int n);
        btn = 1'b1;
        n = 0;
        while (!rolling && n < 40) begin
            tick(1);
            n++;
        end
    endtask

    // Entered on the first sample with rolling high; exits on the first sample with rolling low.
    task automatic roll_phase(input int press_at, output int rc, output int ch, output int rd,
                              output int bad, inout logic [7:0] seen);
        logic [2:0] prev;
        int g;
        rc = 1; ch = 0; rd = 0; bad = 0; g = 0;
        prev = face;
        seen[face] = 1'b1;
        while (rolling && g < 1000) begin
            if (rc == 2) btn = 1'b0;
            if (rc == press_at) btn = 1'b1;
            if (rc == press_at + 8) btn = 1'b0;
            tick(1);
            g++;
            if (face !== prev) ch++;
            prev = face;
            seen[face] = 1'b1;
            if (face < 3'd1 || face > 3'd6) bad++;
            if (roll_done) rd++;
            if (rolling) rc++;
        end
    endtask

    // Entered on the first sample with is_final high; exits on the first sample with it low.
    task automatic final_phase(input int press_at, output int fc, output int ch);
        logic [2:0] prev;
        int g;
        fc = 0; ch = 0; g = 0;
        prev = face;
        while (is_final && g < 1000) begin
            fc++;
            if (fc == press_at) btn = 1'b1;
            tick(1);
            g++;
            if (face !== prev) ch++;
            prev = face;
        end
    endtask

    initial begin
        int n, rc, ch, rd, bad, fc, diffs, rise, errs, bad_tot;
        logic [2:0] face_end;
        logic [7:0] seen;
        logic prev_roll;
        seen = '0;

        // Reset
        #2 rst = 1'b0;
        #1;
        `CHK("rst_face", face, 3'd1)
        `CHK("rst_rolling", rolling, 1'b0)
        `CHK("rst_final", is_final, 1'b0)
        `CHK("rst_done", roll_done, 1'b0)
        tick(5);
        rst = 1'b1;
        tick(1);
        `CHK("post_face", face, 3'd1)
        `CHK("post_rolling", rolling, 1'b0)
        `CHK("post_final", is_final, 1'b0)
        `CHK("post_done", roll_done, 1'b0)
        diffs = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (face !== 3'd1 || rolling !== 1'b0 || is_final !== 1'b0 || roll_done !== 1'b0) diffs++;
        end
        `CHK("idle_stable", diffs, 0)

        // Bounce: 2-cycle pulses never survive the 4-cycle filter
        rise = 0;
        prev_roll = rolling;
        for (int i = 0; i < 10; i++) begin
            btn = ~btn;
            for (int k = 0; k < 2; k++) begin
                tick(1);
                if (rolling && !prev_roll) rise++;
                prev_roll = rolling;
            end
        end
        `CHK("bounce_no_press", rise, 0)
        press_wait(n);
        `CHK("bounce_latency", n, 7)

        // Full roll
        roll_phase(-1, rc, ch, rd, bad, seen);
        `CHK("roll_cycles", rc, 30)
        `CHK("roll_changes", ch, 3)
        `CHK("roll_done_cnt", rd, 1)
        `CHK("roll_range", bad, 0)
        `CHK("final_entered", is_final, 1'b1)
        face_end = face;
        final_phase(-1, fc, ch);
        `CHK("final_cycles", fc, 50)
        `CHK("final_frozen", ch, 0)
        `CHK("idle_rolling", rolling, 1'b0)
        tick(20);
        `CHK("idle_face_kept", face, face_end)
        `CHK("idle_final", is_final, 1'b0)

        // Press during ROLL is ignored; press at FINAL cycle 20 re-rolls
        press_wait(n);
        `CHK("press_latency", n, 7)
        roll_phase(10, rc, ch, rd, bad, seen);
        `CHK("ign_roll_cycles", rc, 30)
        `CHK("ign_roll_changes", ch, 3)
        final_phase(14, fc, ch);
        `CHK("reroll_final_cycles", fc, 20)
        `CHK("reroll_rolling", rolling, 1'b1)
        `CHK("reroll_final_low", is_final, 1'b0)

        // Press coinciding with hold expiry wins
        roll_phase(-1, rc, ch, rd, bad, seen);
        `CHK("reroll_cycles", rc, 30)
        final_phase(44, fc, ch);
        `CHK("coll_final_cycles", fc, 50)
        `CHK("coll_rolling", rolling, 1'b1)
        roll_phase(-1, rc, ch, rd, bad, seen);
        `CHK("coll_roll_cycles", rc, 30)
        final_phase(-1, fc, ch);
        `CHK("coll_final_to_idle", fc, 50)
        tick(10);

        // Mid-roll asynchronous reset
        press_wait(n);
        tick(14);
        #2 rst = 1'b0;
        #1;
        `CHK("mid_rst_face", face, 3'd1)
        `CHK("mid_rst_rolling", rolling, 1'b0)
        `CHK("mid_rst_final", is_final, 1'b0)
        `CHK("mid_rst_done", roll_done, 1'b0)
        btn = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(10);
        `CHK("mid_rst_idle", rolling, 1'b0)
        press_wait(n);
        `CHK("mid_rst_latency", n, 7)
        roll_phase(-1, rc, ch, rd, bad, seen);
        `CHK("mid_rst_roll_cycles", rc, 30)
        `CHK("mid_rst_changes", ch, 3)

        // Soak: chained re-rolls at random points in FINAL
        errs = 0;
        bad_tot = 0;
        for (int r = 0; r < 250; r++) begin
            final_phase($urandom_range(1, 40), fc, ch);
            if (!rolling || ch != 0) errs++;
            roll_phase(-1, rc, ch, rd, bad, seen);
            if (rc != 30 || ch != 3 || rd != 1) errs++;
            bad_tot += bad;
        end
        `CHK("soak_roll_errs", errs, 0)
        `CHK("soak_range", bad_tot, 0)
        `CHK("soak_faces_seen", seen, 8'b0111_1110)

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
